// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with level flags, sticky overflow/underflow errors and
// a choice of registered-read or first-word-fall-through output.
module sync_fifo_ext #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_TH  = 6,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       w_enable,
  input  logic                       r_enable,
  output logic [WIDTH-1:0]           r_data,
  output logic                       r_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    level;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode from the registered pointers only; the extra pointer bit
  // distinguishes full from empty.
  assign level        = wptr - rptr;
  assign count        = level;
  assign full         = (level == PW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= PW'(AFULL_TH));
  assign almost_empty = (level <= PW'(AEMPTY_TH));

  assign wr_acc = w_enable && !full;
  assign rd_acc = r_enable && !empty;

  // Pointer update; both wrap modulo 2*DEPTH by natural overflow
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) rptr <= rptr + PW'(1);
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[AW-1:0]] <= w_data;
  end

  // Sticky errors; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_enable && full)       overflow <= 1'b1;
      else if (clr_err)           overflow <= 1'b0;
      if (r_enable && empty)      underflow <= 1'b1;
      else if (clr_err)           underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always visible; popping exposes the next one
      assign r_data  = mem[rptr[AW-1:0]];
      assign r_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_q;
      logic             r_valid_q;

      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          r_data_q  <= '0;
          r_valid_q <= 1'b0;
        end else begin
          r_valid_q <= rd_acc;
          if (rd_acc) r_data_q <= mem[rptr[AW-1:0]];
        end
      end

      assign r_data  = r_data_q;
      assign r_valid = r_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: one registered-read and one FWFT
// instance share stimulus; a vector table plus hand sequences check both.
module tb_sync_fifo_ext;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] w_data = '0;
  logic       w_enable = 1'b0;
  logic       r_enable = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] s_r_data, f_r_data;
  logic       s_r_valid, f_r_valid;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] s_count, f_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk(clk), .aresetn(aresetn), .w_data(w_data), .w_enable(w_enable),
    .r_enable(r_enable), .r_data(s_r_data), .r_valid(s_r_valid),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
  );

  sync_fifo_ext #(.WIDTH(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk(clk), .aresetn(aresetn), .w_data(w_data), .w_enable(w_enable),
    .r_enable(r_enable), .r_data(f_r_data), .r_valid(f_r_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  typedef struct {
    bit       we, re, clr;
    bit [7:0] wd;
    int       cnt;
    bit       full, empty, af, ae, rv, chk_rd;
    bit [7:0] rd;
    bit       ovf, udf;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(bit we, bit re, bit clr, bit [7:0] wd, int cnt,
                              bit fl, bit em, bit af, bit ae, bit rv,
                              bit chk_rd, bit [7:0] rd, bit ovf, bit udf);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.wd = wd; v.cnt = cnt;
    v.full = fl; v.empty = em; v.af = af; v.ae = ae; v.rv = rv;
    v.chk_rd = chk_rd; v.rd = rd; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int q[$];
  int exp_head;

  initial begin
    // Fill: 0x11..0x88, one reject, drain, then error-flag corners
    for (int k = 1; k <= 8; k++)
      vecs[k-1] = mk(1, 0, 0, 8'(k * 17), k, k == 8, 0, k >= 6, k <= 2, 0, 0, 8'h00, 0, 0);
    vecs[8] = mk(1, 0, 0, 8'hFF, 8, 1, 0, 1, 0, 0, 0, 8'h00, 1, 0);
    for (int j = 1; j <= 8; j++)
      vecs[8+j] = mk(0, 1, 0, 8'h00, 8 - j, 0, j == 8, (8 - j) >= 6, (8 - j) <= 2,
                     1, 1, 8'(j * 17), 1, 0);
    vecs[17] = mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 8'h88, 0, 0);
    vecs[18] = mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 1);
    vecs[19] = mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 1);
    vecs[20] = mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", int'(s_count), 0);
    chk("rst_empty", int'(s_empty), 1);
    chk("rst_aempty", int'(s_ae), 1);
    chk("rst_full", int'(s_full), 0);
    chk("rst_afull", int'(s_af), 0);
    chk("rst_rvalid", int'(s_r_valid), 0);
    chk("rst_rdata", int'(s_r_data), 0);
    chk("rst_fwft_rvalid", int'(f_r_valid), 0);
    aresetn = 1'b1;

    for (int i = 0; i < 21; i++) begin
      w_enable = vecs[i].we; r_enable = vecs[i].re; clr_err = vecs[i].clr;
      w_data = vecs[i].wd;
      step();
      chk($sformatf("v%0d_count", i), int'(s_count), vecs[i].cnt);
      chk($sformatf("v%0d_full", i), int'(s_full), int'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), int'(s_empty), int'(vecs[i].empty));
      chk($sformatf("v%0d_afull", i), int'(s_af), int'(vecs[i].af));
      chk($sformatf("v%0d_aempty", i), int'(s_ae), int'(vecs[i].ae));
      chk($sformatf("v%0d_rvalid", i), int'(s_r_valid), int'(vecs[i].rv));
      chk($sformatf("v%0d_ovf", i), int'(s_ovf), int'(vecs[i].ovf));
      chk($sformatf("v%0d_udf", i), int'(s_udf), int'(vecs[i].udf));
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_rdata", i), int'(s_r_data), int'(vecs[i].rd));
    end
    w_enable = 0; r_enable = 0; clr_err = 0;

    // Steady level 4 with concurrent push/pop across pointer wraps
    for (int k = 0; k < 4; k++) begin
      w_enable = 1; w_data = 8'(8'h40 + k); q.push_back(8'h40 + k);
      step();
    end
    chk("lvl4_count", int'(s_count), 4);
    for (int i = 0; i < 20; i++) begin
      w_enable = 1; r_enable = 1; w_data = 8'(8'h50 + i);
      exp_head = q.pop_front();
      q.push_back(8'h50 + i);
      step();
      chk($sformatf("rw%0d_count", i), int'(s_count), 4);
      chk($sformatf("rw%0d_rdata", i), int'(s_r_data), exp_head);
      chk($sformatf("rw%0d_rvalid", i), int'(s_r_valid), 1);
      chk($sformatf("rw%0d_fwft_head", i), int'(f_r_data), q[0]);
    end
    w_enable = 0;
    for (int k = 0; k < 4; k++) begin
      r_enable = 1; exp_head = q.pop_front();
      step();
      chk($sformatf("drain%0d_rdata", k), int'(s_r_data), exp_head);
    end
    r_enable = 0;
    chk("drain_empty", int'(s_empty), 1);

    // FWFT: write into empty shows next cycle, pop empties it
    chk("fwft_idle_rvalid", int'(f_r_valid), 0);
    w_enable = 1; w_data = 8'hA5;
    step();
    w_enable = 0;
    chk("fwft_rvalid", int'(f_r_valid), 1);
    chk("fwft_rdata", int'(f_r_data), 8'hA5);
    r_enable = 1;
    step();
    r_enable = 0;
    chk("fwft_pop_empty", int'(f_empty), 1);
    chk("fwft_pop_rvalid", int'(f_r_valid), 0);

    // Mid-stream asynchronous reset with an error flag set
    r_enable = 1;
    step();
    r_enable = 0;
    chk("pre_rst_udf", int'(s_udf), 1);
    for (int k = 0; k < 5; k++) begin
      w_enable = 1; w_data = 8'(8'h60 + k);
      step();
    end
    w_enable = 0;
    chk("pre_rst_count", int'(s_count), 5);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_count", int'(s_count), 0);
    chk("mid_rst_empty", int'(s_empty), 1);
    chk("mid_rst_udf", int'(s_udf), 0);
    chk("mid_rst_ovf", int'(s_ovf), 0);
    chk("mid_rst_rvalid", int'(s_r_valid), 0);
    chk("mid_rst_fwft_rvalid", int'(f_r_valid), 0);
    step();
    aresetn = 1'b1;
    w_enable = 1; w_data = 8'h3C;
    step();
    w_enable = 0;
    chk("post_rst_count", int'(s_count), 1);
    r_enable = 1;
    step();
    r_enable = 0;
    chk("post_rst_rdata", int'(s_r_data), 8'h3C);
    chk("post_rst_rvalid", int'(s_r_valid), 1);
    chk("post_rst_empty", int'(s_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8: number of entries (power of 2, >=2).
REQ-003 The block SHALL have parameter AFULL_TH, default 6: almost_full asserts when count >= AFULL_TH (1..DEPTH).
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2: almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1).
REQ-005 The block SHALL have parameter FWFT, default 0: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port w_data, input, WIDTH bits: write data.
REQ-009 The block SHALL have port w_enable, input, 1 bit: write request.
REQ-010 The block SHALL have port r_enable, input, 1 bit: read (pop) request.
REQ-011 The block SHALL have port r_data, output, WIDTH bits: read data.
REQ-012 The block SHALL have port r_valid, output, 1 bit: r_data qualifier.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: level flags.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-015 The block SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.
REQ-016 The block SHALL have port clr_err, input, 1 bit: synchronous clear of overflow and underflow.

Function
REQ-017 Write and read pointers SHALL be $clog2(DEPTH)+1 bits; the lower bits address memory and both pointers SHALL wrap naturally modulo 2*DEPTH.
REQ-018 count SHALL equal wptr - rptr modulo 2*DEPTH; full = (count == DEPTH); empty = (count == 0); all flags SHALL be decoded combinationally from registered pointers only.
REQ-019 A write SHALL be accepted iff w_enable && !full; the word is stored at wptr and wptr increments on that edge.
REQ-020 A read SHALL be accepted iff r_enable && !empty; rptr increments on that edge.
REQ-021 For simultaneous accepted read and write, both SHALL take effect on the same edge and count SHALL be unchanged; no write-to-read bypass exists when empty.
REQ-022 With FWFT=0, r_data SHALL be registered with the word at rptr on an accepted read, r_valid SHALL be 1 exactly in the following cycle, and r_data SHALL hold its value otherwise.
REQ-023 With FWFT=1, r_data SHALL present the memory word at rptr combinationally, r_valid SHALL equal !empty, and an accepted read SHALL advance to the next word on the next cycle.
REQ-024 With FWFT=1, a word written into an empty FIFO SHALL appear with r_valid=1 one cycle after the write edge.
REQ-025 w_enable while full SHALL leave memory and pointers unchanged and SHALL set overflow; r_enable while empty SHALL leave pointers unchanged and SHALL set underflow.
REQ-026 overflow and underflow SHALL remain set until a cycle with clr_err=1; if a clear and a new error event occur in the same cycle, the set SHALL take priority.
REQ-027 almost_full and almost_empty SHALL follow count with zero cycles of latency and no hysteresis.

Reset
REQ-028 aresetn=0 SHALL asynchronously force wptr=0, rptr=0, r_data=0, r_valid=0, overflow=0 and underflow=0, which yields count=0, empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-029 Memory contents SHALL NOT be reset, and a reset mid-operation SHALL discard all stored entries.
REQ-030 The first accepted write SHALL be possible on the first rising edge after aresetn deasserts.

Verification (WIDTH=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2)
REQ-031 The bench SHALL cover: FWFT=0, write 0x11..0x88 in 8 cycles -> full=1, count=8 and almost_full asserted from count=6; then 8 reads -> r_data 0x11..0x88 in order, each with r_valid one cycle after its read, and empty=1 at the end.
REQ-032 The bench SHALL cover: full, then w_enable with 0xFF -> overflow=1 and count stays 8; subsequent reads SHALL return no 0xFF; clr_err=1 for one cycle -> overflow=0.
REQ-033 The bench SHALL cover: empty, then r_enable -> underflow=1 with r_valid=0 in the next cycle; clr_err asserted in the same cycle as another underflow -> underflow stays 1.
REQ-034 The bench SHALL cover: count=4, with simultaneous w_enable and r_enable for 20 cycles -> count stays 4, and the pointers wrap at least twice with data order preserved.
REQ-035 The bench SHALL cover: FWFT=1, write 0xA5 into an empty FIFO -> the next cycle shows r_valid=1 and r_data=0xA5; r_enable pops it -> the following cycle shows empty=1 and r_valid=0.
REQ-036 The bench SHALL cover: aresetn pulsed low at count=5 mid-stream -> count=0, empty=1, error flags 0 and r_valid=0 immediately, with normal operation after release.
